// File: rtl/sfif_wbs_gen.sv
// SFIF Wishbone slave register file: control/TX registers, event counters, atomic 32-bit reads over a 16-bit bus, deferred RX FIFO pop.
// Single-cycle ack/err with no wait states; SFIF_WBS_CNT_SAT_EN selects saturating counters and exposes a saturation flag in CTRL[8].
module sfif_wbs_gen #(
    parameter int DW   = 16,
    parameter int AW   = 8,
    parameter int NCNT = 4
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n_i,
    input  logic [DW-1:0]        wb_dat_i,
    input  logic [AW-1:0]        wb_adr_i,
    input  logic [DW/8-1:0]      wb_sel_i,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    input  logic                 wb_we_i,
    output logic [DW-1:0]        wb_dat_o,
    output logic                 wb_ack_o,
    output logic                 wb_err_o,
    output logic [5:0]           ctrl_o,
    output logic [15:0]          tx_cycles_o,
    output logic [15:0]          ipg_cnt_o,
    output logic [15:0]          tx_ctrl_o,
    output logic [31:0]          tx_data_o,
    output logic                 tx_dv_o,
    input  logic [31:0]          rx_data_i,
    input  logic                 rx_empty_i,
    output logic                 rx_pop_o,
    input  logic [NCNT-1:0]      cnt_inc_i,
    output logic [32*NCNT-1:0]   cnt_o
);

    localparam logic [AW-3:0] W_CTRL  = (AW-2)'(0);
    localparam logic [AW-3:0] W_TXC   = (AW-2)'(1);
    localparam logic [AW-3:0] W_IPG   = (AW-2)'(2);
    localparam logic [AW-3:0] W_TXCTL = (AW-2)'(3);
    localparam logic [AW-3:0] W_TXD   = (AW-2)'(4);
    localparam logic [AW-3:0] W_RXD   = (AW-2)'(5);
    localparam logic [AW-3:0] W_CNT0  = (AW-2)'(8);

    logic [5:0]    ctrl_q, ctrl_d;
    logic [15:0]   txc_q, txc_d, ipg_q, ipg_d, txctl_q, txctl_d, hold_q, hold_d;
    logic [31:0]   txd_q, txd_d;
    logic          pend_q, pend_d, ack_q, ack_d, err_q, err_d, dv_q, dv_d, pop_q, pop_d;
    logic [DW-1:0] dat_q, dat_d, rd_dw;
    logic [31:0]   cnt_q [NCNT];
    logic [31:0]   cnt_d [NCNT];

    logic [AW-3:0] word, cnt_word;
    logic          hi_half, top_half, aligned, acc, mapped, atomic, is_rx, cnt_clr, sat_flag;
    logic [31:0]   item, wd32;
    logic [3:0]    be32;

    assign word = wb_adr_i[AW-1:2];
    assign acc  = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;

    // Everything is handled in a 32-bit item domain; the 16-bit bus maps onto one half of it.
    generate
        if (DW == 16) begin : g_dw16
            assign hi_half  = wb_adr_i[1];
            assign top_half = wb_adr_i[1];
            assign aligned  = ~wb_adr_i[0];
            assign wd32     = wb_adr_i[1] ? {wb_dat_i, 16'h0000} : {16'h0000, wb_dat_i};
            assign be32     = wb_adr_i[1] ? {wb_sel_i, 2'b00} : {2'b00, wb_sel_i};
            assign rd_dw    = hi_half ? (atomic ? hold_q : item[31:16]) : item[15:0];
        end else begin : g_dw32
            assign hi_half  = 1'b0;
            assign top_half = 1'b1;
            assign aligned  = (wb_adr_i[1:0] == 2'b00);
            assign wd32     = wb_dat_i;
            assign be32     = wb_sel_i;
            assign rd_dw    = item;
        end
    endgenerate

`ifdef SFIF_WBS_CNT_SAT_EN
    always_comb begin
        sat_flag = 1'b0;
        for (int i = 0; i < NCNT; i++) begin
            if (cnt_q[i] == 32'hFFFF_FFFF) sat_flag = 1'b1;
        end
    end
`else
    assign sat_flag = 1'b0;
`endif

    function automatic logic [15:0] merge16(input logic [15:0] old_v, input logic [15:0] new_v,
                                            input logic [1:0] be);
        merge16 = {be[1] ? new_v[15:8] : old_v[15:8], be[0] ? new_v[7:0] : old_v[7:0]};
    endfunction

    always_comb begin
        item     = '0;
        mapped   = 1'b0;
        atomic   = 1'b0;
        is_rx    = 1'b0;
        cnt_word = word - W_CNT0;
        if (aligned) begin
            case (word)
                W_CTRL:  begin mapped = 1'b1; item = {23'd0, sat_flag, 1'b0, rx_empty_i, ctrl_q}; end
                W_TXC:   begin mapped = 1'b1; item = {16'd0, txc_q}; end
                W_IPG:   begin mapped = 1'b1; item = {16'd0, ipg_q}; end
                W_TXCTL: begin mapped = 1'b1; item = {16'd0, txctl_q}; end
                W_TXD:   begin mapped = 1'b1; item = txd_q; end
                W_RXD:   begin mapped = 1'b1; atomic = 1'b1; is_rx = 1'b1;
                               item = rx_empty_i ? 32'd0 : rx_data_i; end
                default: begin
                    for (int i = 0; i < NCNT; i++) begin
                        if (cnt_word == (AW-2)'(i)) begin
                            mapped = 1'b1;
                            atomic = 1'b1;
                            item   = cnt_q[i];
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        ctrl_d  = ctrl_q;
        txc_d   = txc_q;
        ipg_d   = ipg_q;
        txctl_d = txctl_q;
        txd_d   = txd_q;
        hold_d  = hold_q;
        pend_d  = pend_q;
        dat_d   = dat_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dv_d    = 1'b0;
        pop_d   = 1'b0;
        cnt_clr = 1'b0;
        if (acc) begin
            ack_d = mapped;
            err_d = ~mapped;
            if (!mapped) begin
                dat_d = '0;
            end else if (wb_we_i) begin
                dat_d = '0;
                case (word)
                    W_CTRL: begin
                        if (be32[0]) ctrl_d = wd32[5:0];
                        cnt_clr = be32[0] & wd32[7];
                    end
                    W_TXC:   txc_d   = merge16(txc_q, wd32[15:0], be32[1:0]);
                    W_IPG:   ipg_d   = merge16(ipg_q, wd32[15:0], be32[1:0]);
                    W_TXCTL: txctl_d = merge16(txctl_q, wd32[15:0], be32[1:0]);
                    W_TXD: begin
                        txd_d = {merge16(txd_q[31:16], wd32[31:16], be32[3:2]),
                                 merge16(txd_q[15:0], wd32[15:0], be32[1:0])};
                        dv_d  = top_half;
                    end
                    default: ;
                endcase
            end else begin
                dat_d = rd_dw;
                if (atomic && !hi_half) hold_d = item[31:16];
                if (is_rx && !hi_half && !rx_empty_i) pend_d = 1'b1;
            end
        end
        // The FIFO is popped only once the master has released the bus.
        if (pend_q && !wb_cyc_i) begin
            pop_d  = 1'b1;
            pend_d = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < NCNT; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_clr) cnt_d[i] = 32'd0;
`ifdef SFIF_WBS_CNT_SAT_EN
            else if (cnt_inc_i[i] && cnt_q[i] != 32'hFFFF_FFFF) cnt_d[i] = cnt_q[i] + 32'd1;
`else
            else if (cnt_inc_i[i]) cnt_d[i] = cnt_q[i] + 32'd1;
`endif
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            ctrl_q  <= '0;
            txc_q   <= '0;
            ipg_q   <= '0;
            txctl_q <= '0;
            txd_q   <= '0;
            hold_q  <= '0;
            pend_q  <= 1'b0;
            dat_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dv_q    <= 1'b0;
            pop_q   <= 1'b0;
            cnt_q   <= '{default: '0};
        end else begin
            ctrl_q  <= ctrl_d;
            txc_q   <= txc_d;
            ipg_q   <= ipg_d;
            txctl_q <= txctl_d;
            txd_q   <= txd_d;
            hold_q  <= hold_d;
            pend_q  <= pend_d;
            dat_q   <= dat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dv_q    <= dv_d;
            pop_q   <= pop_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wb_dat_o    = dat_q;
    assign wb_ack_o    = ack_q;
    assign wb_err_o    = err_q;
    assign ctrl_o      = ctrl_q;
    assign tx_cycles_o = txc_q;
    assign ipg_cnt_o   = ipg_q;
    assign tx_ctrl_o   = txctl_q;
    assign tx_data_o   = txd_q;
    assign tx_dv_o     = dv_q;
    assign rx_pop_o    = pop_q;

    generate
        for (genvar g = 0; g < NCNT; g++) begin : g_cnt_o
            assign cnt_o[32*g +: 32] = cnt_q[g];
        end
    endgenerate

endmodule
